grayscale_ctrl: RTL and testbench

//  Sequencer for the grayscale datapath: accepts a raster stream of 24-bit RGB pixels
//  ({R[23:16],G[15:8],B[7:0]}) and packs them into 4-pixel groups.

---
 rtl/grayscale_ctrl.sv | 150 +++++++++++++++
 tb/tb_grayscale_ctrl.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/grayscale_ctrl.sv
// Grayscale sequencer: packs RGB pixels into 4-pixel groups, hands them to the grayscale
// datapath, and forwards each gray result over valid/ready with frame and timeout tracking.
module grayscale_ctrl #(
    parameter int unsigned IMG_WIDTH      = 640,
    parameter int unsigned IMG_HEIGHT     = 480,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [23:0]      pixel_in_i,
    input  logic             pixel_valid_i,
    output logic             pixel_ready_o,
    output logic [3:0][23:0] in_pixel_buffer_o,
    output logic             gray_en_o,
    input  logic             gray_done_i,
    input  logic [7:0]       gray_pixel_i,
    output logic [7:0]       out_gray_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             frame_done_o,
    output logic             busy_o,
    output logic             err_o
);

    localparam int unsigned NumGroups = IMG_WIDTH * IMG_HEIGHT / 4;
    localparam int unsigned GroupW    = (NumGroups > 1) ? $clog2(NumGroups) : 1;
    localparam int unsigned TcntW     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [GroupW-1:0] LastGroup = GroupW'(NumGroups - 1);
    localparam logic [TcntW-1:0]  TcntLast  = TcntW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StFill,
        StConvert,
        StOutput,
        StFdone,
        StError
    } state_e;

    state_e             state_q, state_d;
    logic [3:0][23:0]   buf_q, buf_d;
    logic [1:0]         idx_q, idx_d;
    logic [TcntW-1:0]   tcnt_q, tcnt_d;
    logic [GroupW-1:0]  gcnt_q, gcnt_d;
    logic [7:0]         gray_q, gray_d;
    logic               err_q, err_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            buf_q   <= '0;
            idx_q   <= '0;
            tcnt_q  <= '0;
            gcnt_q  <= '0;
            gray_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            idx_q   <= idx_d;
            tcnt_q  <= tcnt_d;
            gcnt_q  <= gcnt_d;
            gray_q  <= gray_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        idx_d   = idx_q;
        tcnt_d  = tcnt_q;
        gcnt_d  = gcnt_q;
        gray_d  = gray_q;
        err_d   = err_q;
        // Abort outranks everything; the pixel buffer deliberately keeps its contents.
        if (abort_i) begin
            state_d = StIdle;
            idx_d   = '0;
            tcnt_d  = '0;
            gcnt_d  = '0;
            err_d   = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        state_d = StFill;
                        idx_d   = '0;
                        gcnt_d  = '0;
                    end
                end
                StFill: begin
                    if (pixel_valid_i) begin
                        buf_d[idx_q] = pixel_in_i;
                        idx_d        = idx_q + 2'd1;
                        if (idx_q == 2'd3) state_d = StConvert;
                    end
                end
                StConvert: begin
                    // A done on the final allowed cycle still wins over the timeout.
                    if (gray_done_i) begin
                        gray_d  = gray_pixel_i;
                        tcnt_d  = '0;
                        state_d = StOutput;
                    end else if (tcnt_q == TcntLast) begin
                        tcnt_d  = '0;
                        err_d   = 1'b1;
                        state_d = StError;
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
                StOutput: begin
                    if (out_ready_i) begin
                        if (gcnt_q == LastGroup) begin
                            gcnt_d  = '0;
                            state_d = StFdone;
                        end else begin
                            gcnt_d  = gcnt_q + 1'b1;
                            state_d = StFill;
                        end
                    end
                end
                StFdone: state_d = StIdle;
                StError: begin
                    if (start_i) begin
                        state_d = StFill;
                        err_d   = 1'b0;
                        idx_d   = '0;
                        tcnt_d  = '0;
                        gcnt_d  = '0;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign pixel_ready_o     = (state_q == StFill);
    assign gray_en_o         = (state_q == StConvert);
    assign out_valid_o       = (state_q == StOutput);
    assign frame_done_o      = (state_q == StFdone);
    assign busy_o            = (state_q != StIdle) && (state_q != StError);
    assign err_o             = err_q;
    assign in_pixel_buffer_o = buf_q;
    assign out_gray_o        = gray_q;

endmodule

// File: tb/tb_grayscale_ctrl.sv
// Directed bench for grayscale_ctrl on a 8x2 frame (4 groups per frame).
module tb_grayscale_ctrl;

    logic             clk = 1'b0;
    logic             rst_ni;
    logic             start, abort;
    logic [23:0]      pixel_in;
    logic             pixel_valid, pixel_ready;
    logic [3:0][23:0] in_buf;
    logic             gray_en, gray_done;
    logic [7:0]       gray_pixel, out_gray;
    logic             out_valid, out_ready;
    logic             frame_done, busy, err;

    int n_pass = 0;
    int n_total = 0;
    int n_hs = 0;
    int n_fd = 0;

    always #5 clk = ~clk;

    grayscale_ctrl #(
        .IMG_WIDTH(8),
        .IMG_HEIGHT(2),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .start_i          (start),
        .abort_i          (abort),
        .pixel_in_i       (pixel_in),
        .pixel_valid_i    (pixel_valid),
        .pixel_ready_o    (pixel_ready),
        .in_pixel_buffer_o(in_buf),
        .gray_en_o        (gray_en),
        .gray_done_i      (gray_done),
        .gray_pixel_i     (gray_pixel),
        .out_gray_o       (out_gray),
        .out_valid_o      (out_valid),
        .out_ready_i      (out_ready),
        .frame_done_o     (frame_done),
        .busy_o           (busy),
        .err_o            (err)
    );

    always @(posedge clk) begin
        if (out_valid && out_ready) n_hs <= n_hs + 1;
        if (frame_done) n_fd <= n_fd + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_pixel(input logic [23:0] p, input int unsigned gap);
        pixel_valid = 1'b0;
        repeat (gap) tick;
        pixel_in    = p;
        pixel_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (pixel_ready) begin
                tick;
                pixel_valid = 1'b0;
                return;
            end
            tick;
        end
        pixel_valid = 1'b0;
        n_total++;
        $display("FAIL send_pixel: pixel_ready actual=0 required=1 within 50 cycles");
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    task automatic run_group(input logic [23:0] base, input logic [7:0] g, input bit gaps);
        int unsigned d;
        for (int k = 0; k < 4; k++) send_pixel(base + 24'(k), gaps ? $urandom_range(0, 2) : 0);
        n_total++;
        if (gray_en !== 1'b1) $display("FAIL grp_gray_en: actual=%b required=1", gray_en);
        else n_pass++;
        n_total++;
        if (in_buf[0] !== base || in_buf[3] !== base + 24'd3)
            $display("FAIL grp_slots: actual=%h/%h required=%h/%h", in_buf[0], in_buf[3],
                     base, base + 24'd3);
        else n_pass++;
        d = gaps ? $urandom_range(0, 3) : 0;
        repeat (d) tick;
        gray_done  = 1'b1;
        gray_pixel = g;
        tick;
        gray_done  = 1'b0;
        d = gaps ? $urandom_range(0, 3) : 0;
        repeat (d) tick;
        n_total++;
        if (out_valid !== 1'b1 || out_gray !== g)
            $display("FAIL grp_out: actual valid=%b gray=%h required valid=1 gray=%h",
                     out_valid, out_gray, g);
        else n_pass++;
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_ni = 1'b0;
        #12;
        n_total++;
        if (pixel_ready !== 0 || gray_en !== 0 || out_valid !== 0 || frame_done !== 0 ||
            busy !== 0 || err !== 0)
            $display("FAIL reset_ctrl: actual rdy=%b en=%b ov=%b fd=%b busy=%b err=%b required 0",
                     pixel_ready, gray_en, out_valid, frame_done, busy, err);
        else n_pass++;
        n_total++;
        if (in_buf !== '0 || out_gray !== 8'h00)
            $display("FAIL reset_data: actual buf=%h gray=%h required 0", in_buf, out_gray);
        else n_pass++;
        #1 rst_ni = 1'b1;
        tick;
    endtask

    task automatic test_pack;
        pulse_start;
        n_total++;
        if (pixel_ready !== 1'b1 || busy !== 1'b1)
            $display("FAIL pack_fill: actual rdy=%b busy=%b required 1/1", pixel_ready, busy);
        else n_pass++;
        repeat (3) send_pixel(24'h01C109, 0);
        send_pixel(24'hFF0000, 0);
        n_total++;
        if (in_buf[0] !== 24'h01C109 || in_buf[1] !== 24'h01C109 || in_buf[2] !== 24'h01C109 ||
            in_buf[3] !== 24'hFF0000)
            $display("FAIL pack_slots: actual=%h required=ff000001c10901c10901c109", in_buf);
        else n_pass++;
        n_total++;
        if (gray_en !== 1'b1 || pixel_ready !== 1'b0)
            $display("FAIL pack_gray_en: actual en=%b rdy=%b required 1/0", gray_en, pixel_ready);
        else n_pass++;
    endtask

    task automatic test_result;
        int stable_bad = 0;
        repeat (3) tick;
        gray_done  = 1'b1;
        gray_pixel = 8'h5A;
        tick;
        gray_done  = 1'b0;
        gray_pixel = 8'h00;
        n_total++;
        if (out_valid !== 1'b1 || out_gray !== 8'h5A || gray_en !== 1'b0)
            $display("FAIL result_out: actual ov=%b gray=%h en=%b required 1/5a/0",
                     out_valid, out_gray, gray_en);
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            tick;
            if (out_valid !== 1'b1 || out_gray !== 8'h5A) stable_bad++;
        end
        n_total++;
        if (stable_bad !== 0) $display("FAIL result_hold: actual bad_cycles=%0d required=0",
                                       stable_bad);
        else n_pass++;
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        n_total++;
        if (pixel_ready !== 1'b1 || out_valid !== 1'b0 || frame_done !== 1'b0)
            $display("FAIL result_refill: actual rdy=%b ov=%b fd=%b required 1/0/0",
                     pixel_ready, out_valid, frame_done);
        else n_pass++;
    endtask

    task automatic test_frame;
        int hs0, fd0;
        hs0 = n_hs - 1;
        fd0 = n_fd;
        gray_done  = 1'b1;
        gray_pixel = 8'hEE;
        tick;
        gray_done  = 1'b0;
        n_total++;
        if (out_valid !== 1'b0 || out_gray !== 8'h5A || pixel_ready !== 1'b1)
            $display("FAIL frame_ignore_done: actual ov=%b gray=%h rdy=%b required 0/5a/1",
                     out_valid, out_gray, pixel_ready);
        else n_pass++;
        run_group(24'h102030, 8'h11, 1'b1);
        run_group(24'h405060, 8'h22, 1'b1);
        n_total++;
        if (frame_done !== 1'b0 || pixel_ready !== 1'b1)
            $display("FAIL frame_mid: actual fd=%b rdy=%b required 0/1", frame_done, pixel_ready);
        else n_pass++;
        run_group(24'h708090, 8'h33, 1'b1);
        n_total++;
        if (frame_done !== 1'b1 || busy !== 1'b1)
            $display("FAIL frame_done_pulse: actual fd=%b busy=%b required 1/1", frame_done, busy);
        else n_pass++;
        tick;
        n_total++;
        if (frame_done !== 1'b0 || busy !== 1'b0 || pixel_ready !== 1'b0)
            $display("FAIL frame_idle: actual fd=%b busy=%b rdy=%b required 0/0/0",
                     frame_done, busy, pixel_ready);
        else n_pass++;
        n_total++;
        if (n_hs - hs0 !== 4 || n_fd - fd0 !== 1)
            $display("FAIL frame_counts: actual outputs=%0d pulses=%0d required 4/1",
                     n_hs - hs0, n_fd - fd0);
        else n_pass++;
    endtask

    task automatic test_timeout;
        int hi = 0;
        pulse_start;
        for (int k = 0; k < 4; k++) send_pixel(24'h00AA00 + 24'(k), 0);
        for (int i = 0; i < 16; i++) begin
            if (gray_en === 1'b1) hi++;
            tick;
        end
        n_total++;
        if (hi !== 16) $display("FAIL timeout_window: actual gray_en_cycles=%0d required=16", hi);
        else n_pass++;
        n_total++;
        if (err !== 1'b1 || busy !== 1'b0 || gray_en !== 1'b0 || pixel_ready !== 1'b0)
            $display("FAIL timeout_err: actual err=%b busy=%b en=%b rdy=%b required 1/0/0/0",
                     err, busy, gray_en, pixel_ready);
        else n_pass++;
        pulse_start;
        n_total++;
        if (err !== 1'b0 || pixel_ready !== 1'b1 || busy !== 1'b1)
            $display("FAIL timeout_restart: actual err=%b rdy=%b busy=%b required 0/1/1",
                     err, pixel_ready, busy);
        else n_pass++;
    endtask

    task automatic test_timeout_edge;
        for (int k = 0; k < 4; k++) send_pixel(24'h000100 + 24'(k), 0);
        repeat (15) tick;
        gray_done  = 1'b1;
        gray_pixel = 8'h33;
        tick;
        gray_done  = 1'b0;
        n_total++;
        if (out_valid !== 1'b1 || err !== 1'b0 || out_gray !== 8'h33)
            $display("FAIL timeout_edge: actual ov=%b err=%b gray=%h required 1/0/33",
                     out_valid, err, out_gray);
        else n_pass++;
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
    endtask

    task automatic test_abort;
        send_pixel(24'hAAAAAA, 0);
        send_pixel(24'hBBBBBB, 0);
        pixel_in    = 24'hCCCCCC;
        pixel_valid = 1'b1;
        abort       = 1'b1;
        tick;
        abort       = 1'b0;
        pixel_valid = 1'b0;
        n_total++;
        if (busy !== 1'b0 || pixel_ready !== 1'b0 || err !== 1'b0)
            $display("FAIL abort_idle: actual busy=%b rdy=%b err=%b required 0/0/0",
                     busy, pixel_ready, err);
        else n_pass++;
        n_total++;
        if (in_buf[0] !== 24'hAAAAAA || in_buf[1] !== 24'hBBBBBB || in_buf[2] !== 24'h000102)
            $display("FAIL abort_keep_buf: actual=%h/%h/%h required aaaaaa/bbbbbb/000102",
                     in_buf[0], in_buf[1], in_buf[2]);
        else n_pass++;
        start = 1'b1;
        abort = 1'b1;
        tick;
        start = 1'b0;
        abort = 1'b0;
        n_total++;
        if (busy !== 1'b0) $display("FAIL abort_beats_start: actual busy=%b required 0", busy);
        else n_pass++;
        pulse_start;
        send_pixel(24'h111111, 0);
        pulse_start;
        send_pixel(24'h222222, 0);
        send_pixel(24'h333333, 0);
        send_pixel(24'h444444, 0);
        n_total++;
        if (in_buf !== {24'h444444, 24'h333333, 24'h222222, 24'h111111} || gray_en !== 1'b1)
            $display("FAIL abort_refill: actual=%h en=%b required 444444333333222222111111/1",
                     in_buf, gray_en);
        else n_pass++;
        gray_done  = 1'b1;
        gray_pixel = 8'h44;
        tick;
        gray_done  = 1'b0;
        out_ready  = 1'b1;
        tick;
        out_ready  = 1'b0;
        run_group(24'h500000, 8'h55, 1'b0);
        run_group(24'h600000, 8'h66, 1'b0);
        n_total++;
        if (frame_done !== 1'b0) $display("FAIL abort_gcnt_early: actual fd=%b required 0",
                                          frame_done);
        else n_pass++;
        run_group(24'h700000, 8'h77, 1'b0);
        n_total++;
        if (frame_done !== 1'b1) $display("FAIL abort_gcnt_frame: actual fd=%b required 1",
                                          frame_done);
        else n_pass++;
        tick;
    endtask

    task automatic test_async_reset;
        pulse_start;
        for (int k = 0; k < 4; k++) send_pixel(24'h0F0F0F, 0);
        #2 rst_ni = 1'b0;
        #1;
        n_total++;
        if (gray_en !== 1'b0 || busy !== 1'b0 || in_buf !== '0 || out_gray !== 8'h00)
            $display("FAIL async_reset: actual en=%b busy=%b buf=%h gray=%h required 0",
                     gray_en, busy, in_buf, out_gray);
        else n_pass++;
        rst_ni = 1'b1;
        tick;
        n_total++;
        if (busy !== 1'b0 || pixel_ready !== 1'b0)
            $display("FAIL async_reset_idle: actual busy=%b rdy=%b required 0/0", busy,
                     pixel_ready);
        else n_pass++;
    endtask

    initial begin
        start       = 1'b0;
        abort       = 1'b0;
        pixel_in    = '0;
        pixel_valid = 1'b0;
        gray_done   = 1'b0;
        gray_pixel  = '0;
        out_ready   = 1'b0;
        test_reset;
        test_pack;
        test_result;
        test_frame;
        test_timeout;
        test_timeout_edge;
        test_abort;
        test_async_reset;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
